// File: rtl/sd_frame_pkg.sv
// Shared types and helpers for the SD-to-framebuffer multi-slot loader.
package sd_frame_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        STREAM,
        DONE,
        ERR
    } state_t;

    localparam int unsigned SECTOR_BYTES    = 512;
    localparam int unsigned DEFAULT_PIXEL_W = 16;
    localparam int unsigned BYTES_PER_PIXEL = DEFAULT_PIXEL_W / 8;

    // First RAM word of a slot; callers truncate to their address width.
    function automatic logic [31:0] slot_base(input logic [31:0] slot,
                                              input logic [31:0] pixels_per_image);
        return slot * pixels_per_image;
    endfunction

endpackage

// File: rtl/sd_frame_loader_byte_packer.sv
// Big-endian byte-to-word packer: the first byte of a word lands in the MSBs.
module byte_packer
    import sd_frame_pkg::*;
#(
    parameter int unsigned PIXEL_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         byte_data,
    input  logic               valid,
    input  logic               clear,
    output logic [PIXEL_W-1:0] word,
    output logic               word_valid
);

    localparam int unsigned BPW = PIXEL_W / 8;
    localparam int unsigned CW  = (BPW > 1) ? $clog2(BPW) : 1;

    logic [CW-1:0]      cnt_q;
    logic [PIXEL_W-1:0] shift_q;

    // Word is presented in the same cycle its last byte arrives.
    assign word       = PIXEL_W'({shift_q, byte_data});
    assign word_valid = valid && (cnt_q == CW'(BPW - 1));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt_q   <= '0;
            shift_q <= '0;
        end else if (valid) begin
            shift_q <= word;
            cnt_q   <= word_valid ? '0 : cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/sd_frame_loader.sv
// Loads images from the SD reader into framebuffer slots and selects the
// displayed slot at frame boundaries.
module sd_frame_loader
    import sd_frame_pkg::*;
#(
    parameter int unsigned PIXEL_W           = 16,
    parameter int unsigned ADDR_W            = 17,
    parameter int unsigned NUM_SLOTS         = 4,
    parameter int unsigned PIXELS_PER_IMAGE  = 19200,
    parameter int unsigned BASE_SECTOR       = 0,
    parameter int unsigned SECTORS_PER_IMAGE = 75,
    localparam int unsigned SLOT_W           = $clog2(NUM_SLOTS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load_req,
    input  logic [SLOT_W-1:0]    load_slot,
    input  logic [SLOT_W-1:0]    show_slot,
    input  logic                 frame_start,
    output logic                 sd_start_read,
    output logic [31:0]          sd_sector_addr,
    output logic [7:0]           sd_block_count,
    input  logic                 sd_busy,
    input  logic                 sd_error,
    input  logic [7:0]           sd_data,
    input  logic                 sd_data_valid,
    output logic [ADDR_W-1:0]    ram_addr,
    output logic [PIXEL_W-1:0]   ram_data,
    output logic                 ram_we,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [NUM_SLOTS-1:0] slot_valid,
    output logic [SLOT_W-1:0]    disp_slot,
    output logic [ADDR_W-1:0]    disp_base,
    output state_t               state
);

    localparam int unsigned CNT_W = $clog2(PIXELS_PER_IMAGE + 1);
    localparam logic [CNT_W-1:0] PIX_FULL = CNT_W'(PIXELS_PER_IMAGE);

    state_t               state_q, state_d;
    logic [SLOT_W-1:0]    slot_q;
    logic [CNT_W-1:0]     pix_cnt_q;
    logic [1:0]           stream_cyc_q;
    logic [NUM_SLOTS-1:0] slot_valid_q;
    logic [SLOT_W-1:0]    disp_slot_q;
    logic                 error_q;
    logic [31:0]          sector_q;
    logic [7:0]           block_cnt_q;
    logic [ADDR_W-1:0]    ram_addr_q;
    logic [PIXEL_W-1:0]   ram_data_q;
    logic                 ram_we_q;

    logic                 start_load;
    logic                 image_full;
    logic                 err_cond;
    logic                 ok_cond;
    logic                 accept;
    logic [PIXEL_W-1:0]   word;
    logic                 word_valid;
    logic [ADDR_W-1:0]    base_addr;
    logic [NUM_SLOTS-1:0] disp_ok;

    assign start_load = (state_q == IDLE) && load_req;
    assign image_full = (pix_cnt_q == PIX_FULL);
    assign base_addr  = ADDR_W'(slot_base(32'(slot_q), 32'(PIXELS_PER_IMAGE)));

    always_comb begin
        state_d  = state_q;
        err_cond = 1'b0;
        ok_cond  = 1'b0;
        case (state_q)
            IDLE: if (load_req) state_d = CMD;
            CMD: begin
                if (sd_error) begin
                    err_cond = 1'b1;
                    state_d  = ERR;
                end else begin
                    state_d = STREAM;
                end
            end
            STREAM: begin
                // The first two STREAM cycles give the reader time to raise busy.
                if (sd_error || (!sd_busy && stream_cyc_q == 2'd2 && !image_full)) begin
                    err_cond = 1'b1;
                    state_d  = ERR;
                end else if (image_full && !sd_busy) begin
                    ok_cond = 1'b1;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign accept = (state_q == STREAM) && sd_data_valid && !err_cond && !image_full;

    byte_packer #(.PIXEL_W(PIXEL_W)) u_packer (
        .clk        (clk),
        .rst        (rst),
        .byte_data  (sd_data),
        .valid      (accept),
        .clear      (start_load),
        .word       (word),
        .word_valid (word_valid)
    );

    // A slot finishing this cycle is not yet eligible for display.
    assign disp_ok = slot_valid_q & ~(done ? (NUM_SLOTS'(1) << slot_q) : '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            slot_q       <= '0;
            pix_cnt_q    <= '0;
            stream_cyc_q <= '0;
            slot_valid_q <= '0;
            disp_slot_q  <= '0;
            error_q      <= 1'b0;
            sector_q     <= '0;
            block_cnt_q  <= '0;
            ram_addr_q   <= '0;
            ram_data_q   <= '0;
            ram_we_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            ram_we_q <= word_valid;
            if (word_valid) begin
                ram_addr_q <= base_addr + ADDR_W'(pix_cnt_q);
                ram_data_q <= word;
                pix_cnt_q  <= pix_cnt_q + 1'b1;
            end
            if (start_load) begin
                slot_q                  <= load_slot;
                slot_valid_q[load_slot] <= 1'b0;
                error_q                 <= 1'b0;
                sector_q    <= 32'(BASE_SECTOR) + 32'(load_slot) * 32'(SECTORS_PER_IMAGE);
                block_cnt_q <= 8'(SECTORS_PER_IMAGE);
                pix_cnt_q   <= '0;
            end
            if (state_q != STREAM) stream_cyc_q <= '0;
            else if (stream_cyc_q != 2'd2) stream_cyc_q <= stream_cyc_q + 2'd1;
            if (ok_cond) slot_valid_q[slot_q] <= 1'b1;
            if (err_cond) error_q <= 1'b1;
            if (frame_start && disp_ok[show_slot]) disp_slot_q <= show_slot;
        end
    end

    assign sd_start_read  = (state_q == CMD);
    assign busy           = (state_q == CMD) || (state_q == STREAM) || (state_q == DONE);
    assign done           = (state_q == DONE);
    assign sd_sector_addr = sector_q;
    assign sd_block_count = block_cnt_q;
    assign ram_addr       = ram_addr_q;
    assign ram_data       = ram_data_q;
    assign ram_we         = ram_we_q;
    assign error          = error_q;
    assign slot_valid     = slot_valid_q;
    assign disp_slot      = disp_slot_q;
    assign disp_base      = ADDR_W'(slot_base(32'(disp_slot_q), 32'(PIXELS_PER_IMAGE)));
    assign state          = state_q;

endmodule

// File: tb/tb_sd_frame_loader.sv
// Directed/randomized bench: full-size loader (a) and a small-image loader (b)
// sharing stimulus; RAM writes are checked against a byte-level image model.
`timescale 1ns/1ps
module tb_sd_frame_loader;
    import sd_frame_pkg::*;

    localparam int AW = 17;
    localparam int PW = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sel = 1'b0;
    logic       load_req = 1'b0;
    logic [1:0] load_slot = '0;
    logic [1:0] show_slot = '0;
    logic       frame_start = 1'b0;
    logic       sd_busy = 1'b0;
    logic       sd_error = 1'b0;
    logic [7:0] sd_data = '0;
    logic       sd_data_valid = 1'b0;

    logic        start_a, start_b, we_a, we_b, busy_a, busy_b, done_a, done_b, err_a, err_b;
    logic [31:0] sec_a, sec_b;
    logic [7:0]  cnt_a, cnt_b;
    logic [AW-1:0] addr_a, addr_b, dbase_a, dbase_b;
    logic [PW-1:0] data_a, data_b;
    logic [3:0]  sv_a, sv_b;
    logic [1:0]  ds_a, ds_b;
    state_t      st_a, st_b;

    always #5 clk = ~clk;

    sd_frame_loader u_dut_a (
        .clk(clk), .rst(rst), .load_req(load_req & ~sel), .load_slot(load_slot),
        .show_slot(show_slot), .frame_start(frame_start), .sd_start_read(start_a),
        .sd_sector_addr(sec_a), .sd_block_count(cnt_a), .sd_busy(sd_busy),
        .sd_error(sd_error), .sd_data(sd_data), .sd_data_valid(sd_data_valid),
        .ram_addr(addr_a), .ram_data(data_a), .ram_we(we_a), .busy(busy_a),
        .done(done_a), .error(err_a), .slot_valid(sv_a), .disp_slot(ds_a),
        .disp_base(dbase_a), .state(st_a)
    );

    sd_frame_loader #(.PIXELS_PER_IMAGE(300), .SECTORS_PER_IMAGE(2)) u_dut_b (
        .clk(clk), .rst(rst), .load_req(load_req & sel), .load_slot(load_slot),
        .show_slot(show_slot), .frame_start(frame_start), .sd_start_read(start_b),
        .sd_sector_addr(sec_b), .sd_block_count(cnt_b), .sd_busy(sd_busy),
        .sd_error(sd_error), .sd_data(sd_data), .sd_data_valid(sd_data_valid),
        .ram_addr(addr_b), .ram_data(data_b), .ram_we(we_b), .busy(busy_b),
        .done(done_b), .error(err_b), .slot_valid(sv_b), .disp_slot(ds_b),
        .disp_base(dbase_b), .state(st_b)
    );

    wire          m_start = sel ? start_b : start_a;
    wire          m_we    = sel ? we_b : we_a;
    wire          m_busy  = sel ? busy_b : busy_a;
    wire          m_done  = sel ? done_b : done_a;
    wire          m_err   = sel ? err_b : err_a;
    wire [31:0]   m_sec   = sel ? sec_b : sec_a;
    wire [7:0]    m_cnt   = sel ? cnt_b : cnt_a;
    wire [AW-1:0] m_addr  = sel ? addr_b : addr_a;
    wire [AW-1:0] m_dbase = sel ? dbase_b : dbase_a;
    wire [PW-1:0] m_data  = sel ? data_b : data_a;
    wire [3:0]    m_sv    = sel ? sv_b : sv_a;
    wire [1:0]    m_ds    = sel ? ds_b : ds_a;
    wire [2:0]    m_state = sel ? st_b : st_a;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int starts = 0;
    logic [AW-1:0]    first_addr = '0;
    logic [PW-1:0]    first_data = '0;
    logic [7:0]       img[$];
    logic [AW+PW-1:0] exp_q[$];
    logic [AW+PW-1:0] exp_w;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Model: image bytes pair up big-endian into words; only the first ppi words land.
    task automatic prepare(input int slot, input int ppi, input int nbytes);
        int nwords;
        img.delete();
        for (int i = 0; i < nbytes; i++)
            img.push_back(i == 0 ? 8'h12 : (i == 1 ? 8'h34 : 8'($urandom_range(0, 255))));
        nwords = (nbytes / 2 < ppi) ? nbytes / 2 : ppi;
        for (int p = 0; p < nwords; p++)
            exp_q.push_back({AW'(slot * ppi + p), img[2 * p], img[2 * p + 1]});
        wr_cnt = 0;
        starts = 0;
    endtask

    task automatic stream(input int gate_at);
        for (int i = 0; i < img.size(); i++) begin
            while ($urandom_range(0, 7) == 0) begin
                sd_data_valid = 1'b0;
                tick();
            end
            sd_data       = img[i];
            sd_data_valid = 1'b1;
            if (i == gate_at) begin
                load_req  = 1'b1;
                load_slot = 2'd1;
            end
            tick();
            load_req = 1'b0;
        end
        sd_data_valid = 1'b0;
    endtask

    task automatic do_load(input logic [1:0] slot, input int sector, input int count);
        load_slot = slot;
        load_req  = 1'b1;
        tick();
        load_req = 1'b0;
        chk("start_busy", 64'(m_busy), 64'd1);
        chk("start_pulse", 64'(m_start), 64'd1);
        chk("sector_addr", 64'(m_sec), 64'(sector));
        chk("block_count", 64'(m_cnt), 64'(count));
        chk("error_cleared", 64'(m_err), 64'd0);
        sd_busy = 1'b1;
        tick();
        chk("start_one_cycle", 64'(m_start), 64'd0);
        chk("stream_busy", 64'(m_busy), 64'd1);
    endtask

    always @(negedge clk) begin
        if (m_start) starts++;
        if (m_we) begin
            checks++;
            if (wr_cnt == 0) begin
                first_addr = m_addr;
                first_data = m_data;
            end
            wr_cnt++;
            if (exp_q.size() == 0) begin
                errors++;
                $error("FAIL unexpected_write observed addr=%0d data=%0h expected no write", m_addr, m_data);
            end else begin
                exp_w = exp_q.pop_front();
                assert ({m_addr, m_data} === exp_w) else begin
                    errors++;
                    $error("FAIL ram_write observed addr=%0d data=%0h expected addr=%0d data=%0h",
                           m_addr, m_data, exp_w[AW+PW-1:PW], exp_w[PW-1:0]);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset held three cycles.
        repeat (3) tick();
        chk("rst_state", 64'(m_state), 64'(IDLE));
        chk("rst_start", 64'(m_start), 64'd0);
        chk("rst_sector", 64'(m_sec), 64'd0);
        chk("rst_count", 64'(m_cnt), 64'd0);
        chk("rst_ram", 64'({m_addr, m_data, m_we}), 64'd0);
        chk("rst_busy_done_err", 64'({m_busy, m_done, m_err}), 64'd0);
        chk("rst_slot_valid", 64'(m_sv), 64'd0);
        chk("rst_disp", 64'({m_ds, m_dbase}), 64'd0);
        rst = 1'b0;
        tick();

        // Full load of slot 2, with an ignored request mid-stream.
        prepare(2, 19200, 38400);
        do_load(2'd2, 150, 75);
        stream(100);
        tick();
        tick();
        sd_busy = 1'b0;
        tick();
        chk("load2_done", 64'(m_done), 64'd1);
        chk("load2_slot_valid", 64'(m_sv), 64'b0100);
        tick();
        chk("load2_done_pulse", 64'(m_done), 64'd0);
        chk("load2_idle_busy", 64'(m_busy), 64'd0);
        chk("load2_pending", 64'(exp_q.size()), 64'd0);
        chk("load2_writes", 64'(wr_cnt), 64'd19200);
        chk("load2_first_addr", 64'(first_addr), 64'd38400);
        chk("load2_first_data", 64'(first_data), 64'h1234);
        chk("load2_last_addr", 64'(m_addr), 64'd57599);
        chk("gated_req_starts", 64'(starts), 64'd1);

        // Display selection honours slot validity.
        show_slot   = 2'd3;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("disp_invalid_hold", 64'({m_ds, m_dbase}), 64'd0);
        show_slot   = 2'd2;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("disp_slot2", 64'(m_ds), 64'd2);
        chk("disp_base2", 64'(m_dbase), 64'd38400);

        // Mid-stream error; the byte arriving with the error must be dropped.
        prepare(1, 19200, 1001);
        do_load(2'd1, 75, 75);
        stream(-1);
        sd_error      = 1'b1;
        sd_data       = 8'hAA;
        sd_data_valid = 1'b1;
        tick();
        sd_error = 1'b0;
        chk("err_flag", 64'(m_err), 64'd1);
        chk("err_slot_valid", 64'(m_sv), 64'b0100);
        repeat (3) tick();
        sd_data_valid = 1'b0;
        sd_busy       = 1'b0;
        chk("err_sticky", 64'(m_err), 64'd1);
        chk("err_busy", 64'(m_busy), 64'd0);
        chk("err_writes", 64'(wr_cnt), 64'd500);
        chk("err_pending", 64'(exp_q.size()), 64'd0);
        chk("err_disp_hold", 64'(m_ds), 64'd2);

        // New request clears the error; then reset mid-load.
        prepare(1, 19200, 10);
        do_load(2'd1, 75, 75);
        stream(-1);
        rst           = 1'b1;
        sd_data_valid = 1'b1;
        repeat (2) tick();
        sd_data_valid = 1'b0;
        rst           = 1'b0;
        tick();
        sd_busy = 1'b0;
        chk("midrst_state", 64'(m_state), 64'(IDLE));
        chk("midrst_slot_valid", 64'(m_sv), 64'd0);
        chk("midrst_disp", 64'(m_ds), 64'd0);
        chk("midrst_writes", 64'(wr_cnt), 64'd5);
        chk("midrst_pending", 64'(exp_q.size()), 64'd0);

        // Small image: padding bytes discarded, done/frame_start coincidence.
        sel = 1'b1;
        tick();
        prepare(3, 300, 1024);
        do_load(2'd3, 6, 2);
        stream(-1);
        tick();
        tick();
        sd_busy = 1'b0;
        tick();
        chk("pad_done", 64'(m_done), 64'd1);
        chk("pad_slot_valid", 64'(m_sv), 64'b1000);
        show_slot   = 2'd3;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("pad_done_pulse", 64'(m_done), 64'd0);
        chk("pad_coincide_hold", 64'(m_ds), 64'd0);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        chk("pad_disp_slot", 64'(m_ds), 64'd3);
        chk("pad_disp_base", 64'(m_dbase), 64'd900);
        chk("pad_writes", 64'(wr_cnt), 64'd300);
        chk("pad_pending", 64'(exp_q.size()), 64'd0);
        chk("pad_starts", 64'(starts), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
